// File: rtl/scope_capture.sv
// scope_capture: triggered capture engine with decimation, level/edge trigger and pre-trigger depth,
// storing into a circular buffer that is streamed oldest-first over valid/ready after each capture.
module scope_capture #(
   parameter int pDataWidth  = 8,
   parameter int pDepthLog2  = 9,
   parameter int pDecimWidth = 8
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic [pDataWidth-1:0]  iData,
   input  logic                   iData_Valid,
   input  logic                   iArm,
   input  logic                   iForce,
   input  logic                   iTrigRising,
   input  logic [pDataWidth-1:0]  iTrigLevel,
   input  logic [pDepthLog2-1:0]  iPreTrig,
   input  logic [pDecimWidth-1:0] iDecim,
   output logic [pDataWidth-1:0]  oData,
   output logic                   oData_Valid,
   input  logic                   iData_Ready,
   output logic                   oTriggered,
   output logic [2:0]             oState
);
   typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, READOUT} state_t;
   state_t                 state_q, state_d;
   logic [pDecimWidth-1:0] decim_q, decim_d, dcnt_q, dcnt_d;
   logic [pDataWidth-1:0]  level_q, level_d, prev_q, prev_d, data_q;
   logic [pDepthLog2-1:0]  pretrig_q, pretrig_d, wptr_q, wptr_d, cnt_q, cnt_d;
   logic                   rising_q, rising_d, prev_v_q, prev_v_d;
   logic                   valid_q, valid_d, trig_q, trig_d;
   logic                   capture, acc, edge_hit, rd;
   logic [pDataWidth-1:0]  mem [2**pDepthLog2];

   assign capture  = state_q inside {PREFILL, ARMED, POST};
   assign acc      = capture && iData_Valid && dcnt_q == decim_q;
   assign edge_hit = prev_v_q && (rising_q ? (prev_q < level_q && iData >= level_q)
                                           : (prev_q >= level_q && iData < level_q));
   // After the last post-trigger write, wptr already points at the oldest word, so readout walks wptr.
   assign rd          = state_q == READOUT && !valid_q;
   assign oData       = data_q;
   assign oData_Valid = valid_q;
   assign oTriggered  = trig_q;
   assign oState      = state_q;

   always_comb begin
      state_d   = state_q;
      decim_d   = decim_q;
      dcnt_d    = dcnt_q;
      level_d   = level_q;
      prev_d    = prev_q;
      pretrig_d = pretrig_q;
      wptr_d    = wptr_q;
      cnt_d     = cnt_q;
      rising_d  = rising_q;
      prev_v_d  = prev_v_q;
      valid_d   = valid_q;
      trig_d    = 1'b0;
      if (capture && iData_Valid) dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
      if (acc) begin
         prev_d   = iData;
         prev_v_d = 1'b1;
         wptr_d   = wptr_q + 1'b1;
         cnt_d    = cnt_q + 1'b1;
      end
      case (state_q)
         IDLE: if (iArm) begin
            decim_d   = iDecim;
            level_d   = iTrigLevel;
            rising_d  = iTrigRising;
            pretrig_d = iPreTrig;
            dcnt_d    = '0;
            wptr_d    = '0;
            cnt_d     = '0;
            prev_v_d  = 1'b0;
            state_d   = (iPreTrig == '0) ? ARMED : PREFILL;
         end
         PREFILL: if (acc && cnt_q + 1'b1 == pretrig_q) begin
            cnt_d   = '0;
            state_d = ARMED;
         end
         ARMED: if (acc && (iForce || edge_hit)) begin
            trig_d  = 1'b1;
            cnt_d   = '0;
            state_d = (pretrig_q == '1) ? READOUT : POST;
         end
         POST: if (acc && cnt_q + 1'b1 == ~pretrig_q) begin
            cnt_d   = '0;
            state_d = READOUT;
         end
         READOUT: if (!valid_q) begin
            valid_d = 1'b1;
            wptr_d  = wptr_q + 1'b1;
         end else if (iData_Ready) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == '1) ? IDLE : READOUT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst)
      if (iRst) begin
         state_q   <= IDLE;
         decim_q   <= '0;
         dcnt_q    <= '0;
         level_q   <= '0;
         prev_q    <= '0;
         pretrig_q <= '0;
         wptr_q    <= '0;
         cnt_q     <= '0;
         rising_q  <= 1'b0;
         prev_v_q  <= 1'b0;
         valid_q   <= 1'b0;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         decim_q   <= decim_d;
         dcnt_q    <= dcnt_d;
         level_q   <= level_d;
         prev_q    <= prev_d;
         pretrig_q <= pretrig_d;
         wptr_q    <= wptr_d;
         cnt_q     <= cnt_d;
         rising_q  <= rising_d;
         prev_v_q  <= prev_v_d;
         valid_q   <= valid_d;
         trig_q    <= trig_d;
      end

   always_ff @(posedge iClk)
      if (acc) mem[wptr_q] <= iData;

   always_ff @(posedge iClk or posedge iRst)
      if (iRst) data_q <= '0;
      else if (rd) data_q <= mem[wptr_q];
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: scoreboard bench for scope_capture with a 16-deep buffer.
module tb_scope_capture;
   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] din = '0, level = '0, decim = '0, dout;
   logic [3:0] pretrig = '0;
   logic       din_v = 1'b0, arm = 1'b0, frc = 1'b0, rising = 1'b0, ready = 1'b0;
   logic       dout_v, trig;
   logic [2:0] state;
   int         tests = 0, failed = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   scope_capture #(.pDataWidth(8), .pDepthLog2(4), .pDecimWidth(8)) dut (
      .iClk(clk), .iRst(rst), .iData(din), .iData_Valid(din_v), .iArm(arm), .iForce(frc),
      .iTrigRising(rising), .iTrigLevel(level), .iPreTrig(pretrig), .iDecim(decim),
      .oData(dout), .oData_Valid(dout_v), .iData_Ready(ready), .oTriggered(trig), .oState(state)
   );

   task automatic test_reset();
      @(posedge clk); #1 rst = 1'b1; #2;
      tests++;
      if (state !== 3'd0 || dout_v !== 1'b0 || trig !== 1'b0) begin
         failed++;
         $display("FAIL reset_async: state=%0d valid=%0b trig=%0b required 0/0/0", state, dout_v, trig);
      end
      for (int i = 0; i < 10; i++) begin
         din_v = i[0];
         din   = 8'(i);
         arm   = i[0];
         @(posedge clk); #1;
         tests++;
         if (state !== 3'd0 || dout_v !== 1'b0 || trig !== 1'b0 || dout !== 8'd0) begin
            failed++;
            $display("FAIL reset_hold[%0d]: state=%0d valid=%0b trig=%0b data=%0d required all 0", i, state, dout_v, trig, dout);
         end
      end
      rst = 1'b0; din_v = 1'b0; arm = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (state !== 3'd0 || dout_v !== 1'b0) begin
         failed++;
         $display("FAIL reset_release: state=%0d valid=%0b required 0/0", state, dout_v);
      end
   endtask

   task automatic do_arm(input string name, input int dc, input int lv, input bit rs, input int pt, input int exp_state);
      @(posedge clk); #1;
      decim = 8'(dc); level = 8'(lv); rising = rs; pretrig = 4'(pt); arm = 1'b1; din_v = 1'b0;
      @(posedge clk); #1;
      arm = 1'b0;
      decim = ~decim; level = ~level; rising = ~rising; pretrig = ~pretrig;
      tests++;
      if (state !== 3'(exp_state)) begin
         failed++;
         $display("FAIL %s arm_state: got %0d required %0d", name, state, exp_state);
      end
   endtask

   task automatic feed(input string name, input int start, input int step, input int gap,
                       input bit frc_on, input bit poke, input int stop, input int exp_trig);
      int val, cyc, pulses, tv, last, k;
      val = start; cyc = 0; pulses = 0; tv = -1; last = -1; k = 0;
      while (cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (trig === 1'b1) begin
            pulses++;
            tv = last;
         end
         if (state === 3'(stop)) break;
         if (cyc % gap == 0) begin
            din = 8'(val); din_v = 1'b1; last = val; val += step; k++;
         end else din_v = 1'b0;
         frc = frc_on;
         arm = poke && k == 50;
      end
      din_v = 1'b0; frc = 1'b0; arm = 1'b0;
      tests++;
      if (state !== 3'(stop)) begin
         failed++;
         $display("FAIL %s reach_state: got %0d required %0d", name, state, stop);
      end
      tests++;
      if (pulses != 1 || tv != exp_trig) begin
         failed++;
         $display("FAIL %s trigger: pulses=%0d sample=%0d required pulses=1 sample=%0d", name, pulses, tv, exp_trig);
      end
   endtask

   task automatic readout(input string name, input bit bp);
      int n, cyc;
      logic held;
      logic [7:0] hv, exp;
      n = 0; cyc = 0; held = 1'b0; hv = '0;
      while (n < 16 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (held) begin
            tests++;
            if (dout_v !== 1'b1 || dout !== hv) begin
               failed++;
               $display("FAIL %s hold: valid=%0b data=%0d required valid=1 data=%0d", name, dout_v, dout, hv);
            end
         end
         ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         held  = dout_v && !ready;
         hv    = dout;
         if (dout_v === 1'b1 && ready) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            tests++;
            if (dout !== exp) begin
               failed++;
               $display("FAIL %s word[%0d]: got %0d required %0d", name, n, dout, exp);
            end
            n++;
         end
      end
      @(posedge clk); #1;
      ready = 1'b0;
      tests++;
      if (n != 16 || dout_v !== 1'b0 || state !== 3'd0 || sb.size() != 0) begin
         failed++;
         $display("FAIL %s done: words=%0d valid=%0b state=%0d left=%0d required 16/0/0/0", name, n, dout_v, state, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_rising();
      do_arm("rising", 0, 100, 1'b1, 4, 1);
      for (int v = 96; v <= 111; v++) sb.push_back(8'(v));
      feed("rising", 0, 1, 3, 1'b0, 1'b0, 4, 100);
      readout("rising", 1'b0);
   endtask

   task automatic test_decim(input string name, input bit bp);
      do_arm(name, 2, 50, 1'b1, 0, 2);
      for (int v = 50; v <= 95; v += 3) sb.push_back(8'(v));
      feed(name, 0, 1, 1, 1'b0, 1'b0, 4, 50);
      readout(name, bp);
   endtask

   task automatic test_falling_force();
      do_arm("falling", 0, 10, 1'b0, 15, 1);
      for (int v = 24; v >= 9; v--) sb.push_back(8'(v));
      feed("falling", 30, -1, 2, 1'b0, 1'b0, 4, 9);
      readout("falling", 1'b0);
      do_arm("force", 0, 10, 1'b0, 15, 1);
      for (int i = 0; i < 16; i++) sb.push_back(8'd77);
      feed("force", 77, 0, 2, 1'b1, 1'b0, 4, 77);
      readout("force", 1'b0);
   endtask

   task automatic test_abort_rearm();
      do_arm("abort", 0, 100, 1'b1, 4, 1);
      feed("abort", 0, 1, 3, 1'b0, 1'b0, 3, 100);
      rst = 1'b1; #1;
      tests++;
      if (state !== 3'd0 || dout_v !== 1'b0 || trig !== 1'b0) begin
         failed++;
         $display("FAIL abort_async: state=%0d valid=%0b trig=%0b required 0/0/0", state, dout_v, trig);
      end
      @(posedge clk); #1 rst = 1'b0;
      do_arm("rearm", 0, 100, 1'b1, 4, 1);
      for (int v = 96; v <= 111; v++) sb.push_back(8'(v));
      feed("rearm", 0, 1, 3, 1'b0, 1'b1, 4, 100);
      readout("rearm", 1'b0);
   endtask

   initial begin
      test_reset();
      test_rising();
      test_decim("decim", 1'b0);
      test_falling_force();
      test_decim("backpressure", 1'b1);
      test_abort_rearm();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
